fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_sequencer.sv | 58 +++++
 tb/tb_fetch_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control, program-counter, ROM and decode handshake bundle for the fetch sequencer
interface fetch_sequencer_if #(parameter int AW = 12, parameter int IW = 9);
  logic go;
  logic [AW-1:0] startAddr;
  logic [AW-1:0] pcAddr;
  logic pcDone;
  logic start;
  logic [AW-1:0] startingAddress;
  logic nextIns;
  logic [AW-1:0] romAddr;
  logic [IW-1:0] romData;
  logic [IW-1:0] instr;
  logic instrValid;
  logic instrAccept;
  logic busy;
  logic finished;
  logic [15:0] instrCount;
  modport slave (
    input go, startAddr, pcAddr, pcDone, romData, instrAccept,
    output start, startingAddress, nextIns, romAddr, instr, instrValid, busy, finished, instrCount
  );
  modport master (
    output go, startAddr, pcAddr, pcDone, romData, instrAccept,
    input start, startingAddress, nextIns, romAddr, instr, instrValid, busy, finished, instrCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives a program counter and synchronous ROM, presenting one instruction at a time to decode
module fetch_sequencer #(
  parameter int AW = 12,
  parameter int IW = 9
) (
  input logic clock,
  input logic reset,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, ROMWAIT, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] instr_q;
  logic [AW-1:0] pc_addr;
  logic valid_q;
  logic [15:0] count_q;
  logic accept_fire;
  assign pc_addr = bus.pcAddr;
  assign accept_fire = (state == HOLD) && bus.instrAccept;
  assign bus.start = (state == LOAD);
  assign bus.nextIns = accept_fire;
  assign bus.startingAddress = bus.startAddr;
  assign bus.romAddr = pc_addr;
  assign bus.busy = (state != IDLE) && (state != DONE);
  assign bus.finished = (state == DONE);
  assign bus.instr = instr_q;
  assign bus.instrValid = valid_q;
  assign bus.instrCount = count_q;
  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next-state: go only matters at rest, pcDone only at the fetch decision point
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.go ? LOAD : IDLE;
      LOAD: state_n = FETCH;
      FETCH: state_n = bus.pcDone ? DONE : ROMWAIT;
      ROMWAIT: state_n = HOLD;
      HOLD: state_n = bus.instrAccept ? FETCH : HOLD;
      DONE: state_n = bus.go ? LOAD : DONE;
      default: state_n = IDLE;
    endcase
  end
  // capture the ROM word, track its validity and count accepted instructions (saturating)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      instr_q <= (state == ROMWAIT) ? bus.romData : instr_q;
      valid_q <= (state == ROMWAIT) || ((state == HOLD) && !bus.instrAccept);
      count_q <= (state == LOAD) ? 16'd0 : (accept_fire && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scenario tasks with a scoreboard of expected instruction words
module tb_fetch_sequencer;
  localparam int AW = 12;
  localparam int IW = 9;
  logic clock = 1'b0;
  logic reset = 1'b1;
  fetch_sequencer_if #(.AW(AW), .IW(IW)) bus();
  fetch_sequencer #(.AW(AW), .IW(IW)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  logic [IW-1:0] rom [0:(1<<AW)-1];
  logic [IW-1:0] rom_q;
  logic [AW-1:0] pc;
  logic [AW-1:0] end_addr;
  logic [IW-1:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int next_cnt = 0;
  bit valid_seen = 0;

  always @(posedge clock) rom_q <= rom[bus.romAddr];
  always @(posedge clock or posedge reset)
    if (reset) pc <= '0;
    else if (bus.start) pc <= bus.startingAddress;
    else if (bus.nextIns) pc <= pc + 1'b1;
  assign bus.pcAddr = pc;
  assign bus.pcDone = (pc == end_addr);
  assign bus.romData = rom_q;

  task automatic monitor();
    logic [IW-1:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.start) start_cnt++;
        if (bus.nextIns) next_cnt++;
        if (bus.instrValid) valid_seen = 1;
        total++;
        if (bus.nextIns !== (bus.instrValid && bus.instrAccept) || (bus.start && bus.nextIns)) begin
          bad++;
          $display("FAIL nextins_rule got nextIns=%b start=%b expected nextIns=%b and not both", bus.nextIns, bus.start, bus.instrValid && bus.instrAccept);
        end
        total++;
        if (bus.romAddr !== bus.pcAddr) begin
          bad++;
          $display("FAIL romaddr got %h expected %h", bus.romAddr, bus.pcAddr);
        end
        if (bus.instrValid && bus.instrAccept) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got instr=%h expected none", bus.instr);
          end else begin
            e = exp_q.pop_front();
            if (bus.instr !== e) begin
              bad++;
              $display("FAIL scoreboard got instr=%h expected %h", bus.instr, e);
            end
          end
        end
      end
    end
  endtask

  task automatic load_prog(input logic [AW-1:0] a, input int n, input logic [IW-1:0] base);
    for (int i = 0; i < n; i++) begin
      rom[a + AW'(i)] = base + IW'(i);
      exp_q.push_back(base + IW'(i));
    end
    end_addr = a + AW'(n);
    bus.startAddr = a;
  endtask

  task automatic go_pulse();
    @(posedge clock); #1;
    bus.go = 1'b1;
    @(posedge clock); #1;
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.finished !== 1'b1 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    total++;
    if (bus.finished !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_timeout got finished=%b expected 1", name, bus.finished);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.instrValid !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    total++;
    if (bus.instrValid !== 1'b1) begin
      bad++;
      $display("FAIL %s_valid_timeout got instrValid=%b expected 1", name, bus.instrValid);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock); #1;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_finished", 32'(bus.finished), 0);
    chk("reset_valid", 32'(bus.instrValid), 0);
    chk("reset_start", 32'(bus.start), 0);
    chk("reset_instr", 32'(bus.instr), 0);
    chk("reset_count", 32'(bus.instrCount), 0);
    reset = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("idle_hold_busy", 32'(bus.busy), 0);
    chk("idle_hold_start", 32'(start_cnt), 0);
  endtask

  task automatic test_basic();
    int s0, n0;
    load_prog(12'h010, 3, 9'h0A1);
    bus.instrAccept = 1'b1;
    s0 = start_cnt;
    n0 = next_cnt;
    chk("starting_address", 32'(bus.startingAddress), 32'h010);
    go_pulse();
    wait_done("basic");
    chk("basic_start_pulses", 32'(start_cnt - s0), 1);
    chk("basic_nextins_pulses", 32'(next_cnt - n0), 3);
    chk("basic_count", 32'(bus.instrCount), 3);
    chk("basic_busy", 32'(bus.busy), 0);
    chk("basic_sb_left", 32'(exp_q.size()), 0);
  endtask

  task automatic test_stall();
    int n0;
    load_prog(12'h020, 2, 9'h0B1);
    bus.instrAccept = 1'b0;
    go_pulse();
    wait_valid("stall");
    n0 = next_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_valid", 32'(bus.instrValid), 1);
      chk("stall_instr", 32'(bus.instr), 32'h0B1);
      chk("stall_nextins", 32'(bus.nextIns), 0);
      @(posedge clock); #1;
    end
    bus.instrAccept = 1'b1;
    @(negedge clock);
    chk("stall_release_nextins", 32'(bus.nextIns), 1);
    @(posedge clock); #1;
    bus.instrAccept = 1'b0;
    repeat (2) @(posedge clock); #1;
    chk("stall_one_pulse", 32'(next_cnt - n0), 1);
    bus.instrAccept = 1'b1;
    wait_done("stall");
    chk("stall_count", 32'(bus.instrCount), 2);
  endtask

  task automatic test_immediate_done();
    int s0;
    load_prog(12'h040, 0, 9'h000);
    bus.instrAccept = 1'b1;
    s0 = start_cnt;
    valid_seen = 0;
    go_pulse();
    wait_done("immediate");
    chk("immediate_never_valid", 32'(valid_seen), 0);
    chk("immediate_count", 32'(bus.instrCount), 0);
    chk("immediate_start", 32'(start_cnt - s0), 1);
  endtask

  task automatic test_restart();
    int s0;
    load_prog(12'h050, 3, 9'h0C1);
    bus.instrAccept = 1'b1;
    go_pulse();
    wait_done("restart_a");
    chk("restart_count_a", 32'(bus.instrCount), 3);
    load_prog(12'h060, 2, 9'h0D1);
    bus.instrAccept = 1'b0;
    go_pulse();
    chk("restart_load_start", 32'(bus.start), 1);
    @(posedge clock); #1;
    chk("restart_count_cleared", 32'(bus.instrCount), 0);
    wait_valid("restart");
    s0 = start_cnt;
    go_pulse();
    chk("restart_go_in_hold_valid", 32'(bus.instrValid), 1);
    chk("restart_go_in_hold_busy", 32'(bus.busy), 1);
    chk("restart_go_in_hold_start", 32'(start_cnt - s0), 0);
    bus.instrAccept = 1'b1;
    wait_done("restart_b");
    chk("restart_count_b", 32'(bus.instrCount), 2);
  endtask

  task automatic test_reset_mid_run();
    int s0;
    load_prog(12'h070, 2, 9'h0E1);
    bus.instrAccept = 1'b0;
    go_pulse();
    wait_valid("midreset");
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    chk("midreset_valid", 32'(bus.instrValid), 0);
    chk("midreset_busy", 32'(bus.busy), 0);
    chk("midreset_instr", 32'(bus.instr), 0);
    chk("midreset_count", 32'(bus.instrCount), 0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("midreset_idle", 32'({bus.busy, bus.finished}), 0);
    load_prog(12'h070, 2, 9'h0E1);
    bus.instrAccept = 1'b1;
    s0 = start_cnt;
    go_pulse();
    wait_done("midreset");
    chk("midreset_restart_start", 32'(start_cnt - s0), 1);
    chk("midreset_restart_count", 32'(bus.instrCount), 2);
  endtask

  task automatic test_saturation();
    logic [15:0] want;
    load_prog(12'h100, 4, 9'h1A0);
    bus.instrAccept = 1'b0;
    go_pulse();
    wait_valid("sat");
    force dut.count_q = 16'hFFFD;
    #1;
    release dut.count_q;
    want = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      wait_valid("sat");
      bus.instrAccept = 1'b1;
      @(posedge clock); #1;
      bus.instrAccept = 1'b0;
      chk("sat_count", 32'(bus.instrCount), 32'(want));
      want = (want == 16'hFFFF) ? 16'hFFFF : want + 16'd1;
    end
    wait_done("sat");
    chk("sat_final", 32'(bus.instrCount), 32'hFFFF);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
    bus.go = 1'b0;
    bus.startAddr = '0;
    bus.instrAccept = 1'b0;
    end_addr = '1;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_stall();
    test_immediate_done();
    test_restart();
    test_reset_mid_run();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
